// File: rtl/risc_v_pkg.sv
// Shared definitions for the RISC_V boot path: loader state encoding and
// stream framing constants.
package risc_v_pkg;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        RUN,
        ERR
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 16;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: the first byte loaded lands in the
// least significant lane; word_valid pulses alongside the final byte.
module byte_packer
    import risc_v_pkg::*;
(
    input  logic                          clk,
    input  logic                          load,
    input  logic                          clear,
    input  logic [7:0]                    byte_in,
    output logic [BYTES_PER_WORD*8-1:0]   word_out,
    output logic                          word_valid
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned LOW_W = (BYTES_PER_WORD - 1) * 8;

    logic [IDX_W-1:0] byte_idx;
    logic [LOW_W-1:0] low_bytes;

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_idx  <= '0;
            low_bytes <= '0;
        end else if (load) begin
            low_bytes <= {byte_in, low_bytes[LOW_W-1:8]};
            byte_idx  <= byte_idx + IDX_W'(1);
        end
    end

    // The last byte bypasses the register so the full word is ready in the
    // same cycle it arrives.
    assign word_out   = {byte_in, low_bytes};
    assign word_valid = load && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed byte image, writes it into
// instruction memory from word 0 and releases the core once it verifies.
module imem_loader
    import risc_v_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    // One extra bit so a full DEPTH-word image counts to DEPTH without wrapping.
    localparam int unsigned IDX_W = ADDR_W + 1;

    loader_state_t state, state_next;

    logic             accept;
    logic             load;
    logic             clear;
    logic             word_valid;
    logic [WIDTH-1:0] word_out;
    logic [7:0]       cnt_lo;
    logic [7:0]       chk_acc;
    logic [CNT_W-1:0] count;
    logic             count_bad;
    logic [IDX_W-1:0] word_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] idx_next;
    logic             last_word;

    assign accept    = s_valid && s_ready;
    assign load      = accept && (state == DATA);
    assign clear     = rst || (state != DATA);
    assign count     = {s_data, cnt_lo};
    assign count_bad = (count == '0) || (count > CNT_W'(DEPTH));
    assign idx_next  = word_idx + IDX_W'(1);
    assign last_word = word_valid && (idx_next == word_cnt);

    byte_packer u_packer (
        .clk        (clk),
        .load       (load),
        .clear      (clear),
        .byte_in    (s_data),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CNT_LO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CNT_LO: if (accept) state_next = CNT_HI;
            CNT_HI: if (accept) state_next = count_bad ? ERR : DATA;
            DATA:   if (accept && last_word) state_next = CHK;
            CHK:    if (accept) state_next = (s_data == chk_acc) ? RUN : ERR;
            default: state_next = state;
        endcase
    end

    always_comb begin
        s_ready    = !rst && (state inside {CNT_LO, CNT_HI, DATA, CHK});
        done       = (state == RUN);
        core_rst_n = (state == RUN);
        err        = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_lo    <= '0;
            word_cnt  <= '0;
            word_idx  <= '0;
            chk_acc   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept && state == CNT_LO) begin
                cnt_lo <= s_data;
            end
            if (accept && state == CNT_HI) begin
                word_cnt <= count[IDX_W-1:0];
                word_idx <= '0;
                chk_acc  <= '0;
            end
            if (load) begin
                chk_acc <= chk_acc ^ s_data;
                if (word_valid) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_idx[ADDR_W-1:0];
                    mem_wdata <= word_out;
                    word_idx  <= idx_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven and random images checked against a
// byte-level model of the stream format, plus reset corner sequences.
module tb_imem_loader;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int unsigned       cyc;
    } wr_t;

    typedef struct {
        int unsigned n;
        bit          corrupt;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    wr_t         seen[$];
    int unsigned exp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) seen.push_back('{mem_addr, mem_wdata, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        @(negedge clk);
        check("rst s_ready", 32'(s_ready), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst core_rst_n", 32'(core_rst_n), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst s_ready", 32'(s_ready), 1);
        seen.delete();
        exp_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit word_end);
        int unsigned budget;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        budget  = 20;
        while (!s_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!s_ready) begin
            check("s_ready timeout", 32'(s_ready), 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (word_end) exp_cyc.push_back(cyc);
        @(negedge clk);
    endtask

    // Reference: word i is bytes 4i..4i+3, least significant first.
    function automatic logic [31:0] word_of(input logic [7:0] p[$], input int unsigned i);
        return 32'(p[4*i]) | (32'(p[4*i+1]) << 8) | (32'(p[4*i+2]) << 16) | (32'(p[4*i+3]) << 24);
    endfunction

    function automatic logic [7:0] xor_of(input logic [7:0] p[$]);
        logic [7:0] x = '0;
        foreach (p[i]) x = x ^ p[i];
        return x;
    endfunction

    task automatic run_stream(input string tag, input logic [15:0] n16, input logic [7:0] pay[$],
                              input logic [7:0] chk, input bit gaps, input bit exp_done, input bit exp_err);
        bit          n_ok;
        int unsigned exp_n;
        do_reset();
        n_ok = (n16 >= 1) && (n16 <= DEPTH);
        send_byte(n16[7:0], gaps, 1'b0);
        send_byte(n16[15:8], gaps, 1'b0);
        if (n_ok) begin
            foreach (pay[i]) send_byte(pay[i], gaps, (i % 4) == 3);
            send_byte(chk, gaps, 1'b0);
        end
        s_valid = 1'b0;
        check({tag, " done"}, 32'(done), 32'(exp_done));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
        check({tag, " s_ready after"}, 32'(s_ready), 0);
        repeat (3) @(negedge clk);
        check({tag, " done sticky"}, 32'(done), 32'(exp_done));
        check({tag, " err sticky"}, 32'(err), 32'(exp_err));
        exp_n = n_ok ? 32'(n16) : 0;
        check({tag, " write count"}, seen.size(), exp_n);
        for (int unsigned i = 0; i < exp_n && i < seen.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), 32'(seen[i].addr), i);
            check($sformatf("%s data[%0d]", tag, i), seen[i].data, word_of(pay, i));
            if (i < exp_cyc.size())
                check($sformatf("%s latency[%0d]", tag, i), seen[i].cyc, exp_cyc[i]);
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic [7:0]  pay[$];
        logic [7:0]  chk;
        logic [7:0]  fixed[$];
        int unsigned n;
        bit          corrupt;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        @(negedge clk);

        vecs[0] = '{1,   0, 0, 1, 0};
        vecs[1] = '{2,   0, 1, 1, 0};
        vecs[2] = '{0,   0, 0, 0, 1};
        vecs[3] = '{65,  0, 0, 0, 1};
        vecs[4] = '{256, 0, 1, 0, 1};
        vecs[5] = '{64,  0, 1, 1, 0};
        vecs[6] = '{64,  1, 0, 0, 1};
        vecs[7] = '{3,   1, 1, 0, 1};
        vecs[8] = '{63,  0, 0, 1, 0};

        foreach (vecs[v]) begin
            pay.delete();
            if (vecs[v].n >= 1 && vecs[v].n <= DEPTH)
                for (int unsigned i = 0; i < vecs[v].n * 4; i++) pay.push_back(8'($urandom));
            chk = xor_of(pay) ^ (vecs[v].corrupt ? 8'h5A : 8'h00);
            run_stream($sformatf("vec%0d", v), vecs[v].n[15:0], pay, chk, vecs[v].gaps,
                       vecs[v].exp_done, vecs[v].exp_err);
        end

        fixed = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        run_stream("fixed good", 16'd2, fixed, 8'h20, 1'b0, 1'b1, 1'b0);
        if (seen.size() == 2) begin
            check("fixed w0", seen[0].data, 32'h0000_0013);
            check("fixed w1", seen[1].data, 32'h00A0_0093);
        end
        run_stream("fixed badchk", 16'd2, fixed, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            corrupt = 1'($urandom_range(0, 1));
            pay.delete();
            for (int unsigned i = 0; i < n * 4; i++) pay.push_back(8'($urandom));
            chk = xor_of(pay) ^ (corrupt ? 8'(1 + $urandom_range(0, 254)) : 8'h00);
            run_stream($sformatf("rand%0d", r), n[15:0], pay, chk, 1'b1, !corrupt, corrupt);
        end

        // Abort mid-image, with a byte offered in the reset cycle.
        do_reset();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        rst     = 1'b1;
        @(negedge clk);
        check("abort s_ready", 32'(s_ready), 0);
        check("abort mem_wdata", mem_wdata, 0);
        check("abort writes", seen.size(), 1);
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("abort rearm s_ready", 32'(s_ready), 1);
        seen.delete();
        exp_cyc.delete();
        fixed = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        foreach (fixed[i]) send_byte(fixed[i], 1'b0, i == 5);
        s_valid = 1'b0;
        check("reload done", 32'(done), 1);
        check("reload writes", seen.size(), 1);
        if (seen.size() >= 1) begin
            check("reload addr", 32'(seen[0].addr), 0);
            check("reload data", seen[0].data, 32'hDEAD_BEEF);
            if (exp_cyc.size() >= 1) check("reload latency", seen[0].cyc, exp_cyc[0]);
        end

        // Reset while running.
        rst = 1'b1;
        @(negedge clk);
        check("run rst core_rst_n", 32'(core_rst_n), 0);
        rst = 1'b0;
        @(negedge clk);
        check("run rearm core_rst_n", 32'(core_rst_n), 0);
        check("run rearm s_ready", 32'(s_ready), 1);
        check("run rearm done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
